button_mode_ctrl: RTL

Single-button light mode controller. It sequences one light through OFF → ON → BLINK → OFF on successive debounced presses, and forces OFF on a long press. The block sits between a raw push-button pin and the light output. It replaces a bare toggle with a synchronised, filtered, multi-mode scheduler.

---
 rtl/button_mode_pkg.sv | 12 +
 rtl/btn_debounce.sv | 93 +++++++++
 rtl/button_mode_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/button_mode_pkg.sv
// button_mode_pkg: shared types for the single-button light mode controller.
//   MODE_W  - width of the mode encoding driven on the mode output
//   mode_e  - OFF / ON / BLINK encodings (value 3 is never used)
package button_mode_pkg;
   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2
   } mode_e;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions a raw push-button into one-cycle press and
// long-press events.
//   clk_i      - clock, rising edge
//   rst_ni     - synchronous active-low reset
//   button_i   - raw asynchronous button level, active-high
//   press_o    - one-cycle pulse per accepted rising edge of the filtered level
//   long_evt_o - one-cycle pulse when the filtered level has been high long enough
// Build option: BUTTON_MODE_DEBOUNCE_EN enables the DEB_CYCLES stability
// filter; without it the synchronised level is used directly.
module btn_debounce #(
   parameter int DEB_CYCLES  = 4,
   parameter int LONG_CYCLES = 32
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic button_i,
   output logic press_o,
   output logic long_evt_o
);
   localparam int HW = $clog2(LONG_CYCLES + 1);

   logic          s1_q, btn_s_q;
   logic [1:0]    vld_q;
   logic          armed_q;
   logic          btn_db, btn_db_q;
   logic [HW-1:0] hcnt_q;

   // Two-flop synchroniser. vld_q marks when btn_s_q holds a real sample
   // rather than its reset value.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_q    <= 1'b0;
         btn_s_q <= 1'b0;
         vld_q   <= '0;
      end else begin
         s1_q    <= button_i;
         btn_s_q <= s1_q;
         vld_q   <= {vld_q[0], 1'b1};
      end
   end

   // Presses are only honoured once the button has been seen released after
   // reset, so a button held through reset does not count as a press.
   always_ff @(posedge clk_i) begin
      if (!rst_ni)                   armed_q <= 1'b0;
      else if (vld_q[1] && !btn_s_q) armed_q <= 1'b1;
   end

`ifdef BUTTON_MODE_DEBOUNCE_EN
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic          db_q;
   logic [DW-1:0] dcnt_q;

   // Accept a new level only after it has differed for DEB_CYCLES edges in a row.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         db_q   <= 1'b0;
         dcnt_q <= '0;
      end else if (btn_s_q != db_q) begin
         if (dcnt_q == DW'(DEB_CYCLES - 1)) begin
            db_q   <= btn_s_q;
            dcnt_q <= '0;
         end else begin
            dcnt_q <= dcnt_q + 1'b1;
         end
      end else begin
         dcnt_q <= '0;
      end
   end

   assign btn_db = db_q;
`else
   localparam int unused_deb_cycles = DEB_CYCLES;

   assign btn_db = btn_s_q;
`endif

   // Edge delay and hold counter; hcnt saturates so long_evt fires once per hold.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         btn_db_q <= 1'b0;
         hcnt_q   <= '0;
      end else begin
         btn_db_q <= btn_db;
         if (!btn_db)                      hcnt_q <= '0;
         else if (hcnt_q != HW'(LONG_CYCLES)) hcnt_q <= hcnt_q + 1'b1;
      end
   end

   assign press_o    = btn_db & ~btn_db_q & armed_q;
   assign long_evt_o = btn_db & (hcnt_q == HW'(LONG_CYCLES - 1));
endmodule

// File: rtl/button_mode_ctrl.sv
// button_mode_ctrl: single-button light mode controller. Successive presses
// step OFF -> ON -> BLINK -> OFF; a long press forces OFF.
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   button - raw asynchronous button level, active-high
//   light  - registered light drive (0 in OFF, 1 in ON, square wave in BLINK)
//   mode   - registered state: 0 OFF, 1 ON, 2 BLINK
// Build option: BUTTON_MODE_DEBOUNCE_EN (see btn_debounce).
module button_mode_ctrl
   import button_mode_pkg::*;
#(
   parameter int DEB_CYCLES  = 4,
   parameter int BLINK_HALF  = 8,
   parameter int LONG_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              button,
   output logic              light,
   output logic [MODE_W-1:0] mode
);
   localparam logic [MODE_W-1:0] ST_OFF   = MODE_OFF;
   localparam logic [MODE_W-1:0] ST_ON    = MODE_ON;
   localparam logic [MODE_W-1:0] ST_BLINK = MODE_BLINK;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   logic              press, long_evt;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic              light_q, light_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;

   btn_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES)
   ) u_deb (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .button_i   (button),
      .press_o    (press),
      .long_evt_o (long_evt)
   );

   always_comb begin
      mode_d = mode_q;
      if (long_evt) begin
         mode_d = ST_OFF;
      end else if (press) begin
         case (mode_q)
            ST_OFF:  mode_d = ST_ON;
            ST_ON:   mode_d = ST_BLINK;
            default: mode_d = ST_OFF;
         endcase
      end

      // Light follows the next state so a mode change and its light value
      // land on the same edge; bcnt is zero outside BLINK.
      light_d = 1'b0;
      bcnt_d  = '0;
      case (mode_d)
         ST_ON: light_d = 1'b1;
         ST_BLINK: begin
            if (mode_q != ST_BLINK) begin
               light_d = 1'b1;
            end else if (bcnt_q == BW'(BLINK_HALF - 1)) begin
               light_d = ~light_q;
            end else begin
               light_d = light_q;
               bcnt_d  = bcnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q  <= ST_OFF;
         light_q <= 1'b0;
         bcnt_q  <= '0;
      end else begin
         mode_q  <= mode_d;
         light_q <= light_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign mode  = mode_q;
   assign light = light_q;
endmodule
